// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller:
// state codes, opcodes, mux-select encodings and the packed control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Control word held while in reset: every enable off, selects parked at their FETCH values.
    function automatic ctrl_t reset_ctrl();
        ctrl_t c;
        c           = '0;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCSRC_ALU;
        return c;
    endfunction

endpackage

// File: rtl/mips_main_ctrl_if.sv
// Controller <-> datapath signal bundle. master = controller side, slave = datapath side.
interface mips_main_ctrl_if #(
    parameter int OPW = 6,
    parameter int STW = 4
);
    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           pc_write;
    logic           pc_write_cond;
    logic           i_or_d;
    logic           mem_read;
    logic           mem_write;
    logic           ir_write;
    logic           mem_to_reg;
    logic           reg_dst;
    logic           reg_write;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_source;
    logic           illegal_op;
    logic [STW-1:0] state_o;

    // Memory handshake: a request (mem_read/mem_write) is held stable until the cycle mem_ready=1 completes it.
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state_o
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state_o
    );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control-word decoder. Only the FETCH-cycle IR/PC loads look at mem_ready.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t   state,
    input  logic     mem_ready,
    output ctrl_t    ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_main_ctrl.sv
// Multicycle MIPS main control FSM: state register, opcode-driven next state,
// and reset gating of the decoded control word.
module mips_main_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mips_main_ctrl_if.master bus
);

    state_t state;
    state_t state_next;
    logic   illegal;
    ctrl_t  word;
    ctrl_t  ctrl_out;
    logic   illegal_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        illegal    = 1'b0;
        case (state)
            S_FETCH:  state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OPW'(OP_RTYPE):        state_next = S_EXEC;
                    OPW'(OP_LW), OPW'(OP_SW): state_next = S_MEMADR;
                    OPW'(OP_BEQ):          state_next = S_BRANCH;
                    OPW'(OP_ADDI):         state_next = S_ADDIEX;
                    OPW'(OP_J):            state_next = S_JUMP;
                    default: begin
                        state_next = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            // Only lw and sw reach MEMADR, so anything other than sw is a load.
            S_MEMADR: state_next = (bus.opcode == OPW'(OP_SW)) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .ctrl      (word)
    );

    // FETCH would otherwise request memory during reset; hold every enable off until release.
    always_comb begin
        ctrl_out    = word;
        illegal_out = illegal;
        if (!rst_n) begin
            ctrl_out    = reset_ctrl();
            illegal_out = 1'b0;
        end
    end

    assign bus.pc_write      = ctrl_out.pc_write;
    assign bus.pc_write_cond = ctrl_out.pc_write_cond;
    assign bus.i_or_d        = ctrl_out.i_or_d;
    assign bus.mem_read      = ctrl_out.mem_read;
    assign bus.mem_write     = ctrl_out.mem_write;
    assign bus.ir_write      = ctrl_out.ir_write;
    assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
    assign bus.reg_dst       = ctrl_out.reg_dst;
    assign bus.reg_write     = ctrl_out.reg_write;
    assign bus.alu_src_a     = ctrl_out.alu_src_a;
    assign bus.alu_src_b     = ctrl_out.alu_src_b;
    assign bus.alu_op        = ctrl_out.alu_op;
    assign bus.pc_source     = ctrl_out.pc_source;
    assign bus.illegal_op    = illegal_out;
    assign bus.state_o       = STW'(state);

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Directed bench for mips_main_ctrl: walks each instruction class through its
// states and checks control outputs against hand-computed values.
module tb_mips_main_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mips_main_ctrl_if #(.OPW(6), .STW(4)) bus ();

    mips_main_ctrl #(.OPW(6), .STW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.opcode    = 6'b100011;
        bus.mem_ready = 1'b1;
        #12;

        // reset state
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_pc_write", 32'(bus.pc_write), 32'd0);
        chk("rst_ir_write", 32'(bus.ir_write), 32'd0);
        chk("rst_alu_src_b", 32'(bus.alu_src_b), 32'd1);

        rst_n = 1'b1;
        #1;
        chk("fetch_mem_read", 32'(bus.mem_read), 32'd1);
        chk("fetch_ir_write", 32'(bus.ir_write), 32'd1);
        chk("fetch_pc_write", 32'(bus.pc_write), 32'd1);
        chk("fetch_i_or_d", 32'(bus.i_or_d), 32'd0);

        // lw: 0,1,2,3,4,0
        step();
        chk("lw_s1", 32'(bus.state_o), 32'd1);
        chk("lw_dec_srcb", 32'(bus.alu_src_b), 32'd3);
        chk("lw_dec_regw", 32'(bus.reg_write), 32'd0);
        step();
        chk("lw_s2", 32'(bus.state_o), 32'd2);
        chk("lw_adr_srca", 32'(bus.alu_src_a), 32'd1);
        chk("lw_adr_srcb", 32'(bus.alu_src_b), 32'd2);
        step();
        chk("lw_s3", 32'(bus.state_o), 32'd3);
        chk("lw_rd_memrd", 32'(bus.mem_read), 32'd1);
        chk("lw_rd_iord", 32'(bus.i_or_d), 32'd1);
        chk("lw_rd_regw", 32'(bus.reg_write), 32'd0);
        step();
        chk("lw_s4", 32'(bus.state_o), 32'd4);
        chk("lw_wb_regw", 32'(bus.reg_write), 32'd1);
        chk("lw_wb_m2r", 32'(bus.mem_to_reg), 32'd1);
        chk("lw_wb_rdst", 32'(bus.reg_dst), 32'd0);
        step();
        chk("lw_s0", 32'(bus.state_o), 32'd0);

        // R-type
        bus.opcode = 6'b000000;
        step();
        chk("r_s1", 32'(bus.state_o), 32'd1);
        step();
        chk("r_s6", 32'(bus.state_o), 32'd6);
        chk("r_aluop", 32'(bus.alu_op), 32'd2);
        chk("r_srcb", 32'(bus.alu_src_b), 32'd0);
        chk("r_srca", 32'(bus.alu_src_a), 32'd1);
        step();
        chk("r_s7", 32'(bus.state_o), 32'd7);
        chk("r_rdst", 32'(bus.reg_dst), 32'd1);
        chk("r_regw", 32'(bus.reg_write), 32'd1);
        chk("r_m2r", 32'(bus.mem_to_reg), 32'd0);
        step();
        chk("r_s0", 32'(bus.state_o), 32'd0);

        // beq
        bus.opcode = 6'b000100;
        step();
        step();
        chk("beq_s8", 32'(bus.state_o), 32'd8);
        chk("beq_pwc", 32'(bus.pc_write_cond), 32'd1);
        chk("beq_pcsrc", 32'(bus.pc_source), 32'd1);
        chk("beq_aluop", 32'(bus.alu_op), 32'd1);
        chk("beq_pw", 32'(bus.pc_write), 32'd0);
        step();
        chk("beq_s0", 32'(bus.state_o), 32'd0);

        // j
        bus.opcode = 6'b000010;
        step();
        step();
        chk("j_s11", 32'(bus.state_o), 32'd11);
        chk("j_pw", 32'(bus.pc_write), 32'd1);
        chk("j_pcsrc", 32'(bus.pc_source), 32'd2);
        step();
        chk("j_s0", 32'(bus.state_o), 32'd0);

        // addi
        bus.opcode = 6'b001000;
        step();
        step();
        chk("addi_s9", 32'(bus.state_o), 32'd9);
        chk("addi_srcb", 32'(bus.alu_src_b), 32'd2);
        step();
        chk("addi_s10", 32'(bus.state_o), 32'd10);
        chk("addi_regw", 32'(bus.reg_write), 32'd1);
        chk("addi_rdst", 32'(bus.reg_dst), 32'd0);
        chk("addi_m2r", 32'(bus.mem_to_reg), 32'd0);
        step();
        chk("addi_s0", 32'(bus.state_o), 32'd0);

        // sw with 3 wait cycles in MEMWR
        bus.opcode = 6'b101011;
        step();
        step();
        chk("sw_s2", 32'(bus.state_o), 32'd2);
        step();
        chk("sw_s5", 32'(bus.state_o), 32'd5);
        chk("sw_memw_0", 32'(bus.mem_write), 32'd1);
        chk("sw_iord", 32'(bus.i_or_d), 32'd1);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("sw_wait_state_%0d", i), 32'(bus.state_o), 32'd5);
            chk($sformatf("sw_wait_memw_%0d", i), 32'(bus.mem_write), 32'd1);
        end
        bus.mem_ready = 1'b1;
        step();
        chk("sw_s0", 32'(bus.state_o), 32'd0);

        // FETCH waiting on memory
        bus.mem_ready = 1'b0;
        #1;
        chk("fwait_irw", 32'(bus.ir_write), 32'd0);
        chk("fwait_pw", 32'(bus.pc_write), 32'd0);
        chk("fwait_memrd", 32'(bus.mem_read), 32'd1);
        step();
        chk("fwait_hold", 32'(bus.state_o), 32'd0);
        chk("fwait_memrd2", 32'(bus.mem_read), 32'd1);
        bus.mem_ready = 1'b1;

        // illegal opcode
        bus.opcode = 6'b111111;
        step();
        chk("ill_s1", 32'(bus.state_o), 32'd1);
        chk("ill_pulse", 32'(bus.illegal_op), 32'd1);
        chk("ill_regw", 32'(bus.reg_write), 32'd0);
        chk("ill_memw", 32'(bus.mem_write), 32'd0);
        step();
        chk("ill_s0", 32'(bus.state_o), 32'd0);
        chk("ill_drop", 32'(bus.illegal_op), 32'd0);
        chk("ill_regw2", 32'(bus.reg_write), 32'd0);
        chk("ill_memw2", 32'(bus.mem_write), 32'd0);

        // reset while waiting in MEMWR
        bus.opcode = 6'b101011;
        step();
        step();
        step();
        chk("rmid_s5", 32'(bus.state_o), 32'd5);
        bus.mem_ready = 1'b0;
        step();
        chk("rmid_wait", 32'(bus.mem_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_memw", 32'(bus.mem_write), 32'd0);
        chk("rmid_state", 32'(bus.state_o), 32'd0);
        chk("rmid_memrd", 32'(bus.mem_read), 32'd0);
        step();
        chk("rmid_hold", 32'(bus.state_o), 32'd0);
        bus.mem_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("rmid_fetch_rd", 32'(bus.mem_read), 32'd1);
        chk("rmid_fetch_irw", 32'(bus.ir_write), 32'd1);
        step();
        chk("rmid_dec", 32'(bus.state_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_main_ctrl.md
# mips_main_ctrl

Main control state machine for the multicycle MIPS datapath. It decodes the instruction opcode and steps each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath enable, and the select inputs of the datapath's 2- and 4-input multiplexors (ALU operand B, PC source, register destination, writeback source). It sits directly upstream of those muxes and of the PC, IR, register file and memory enables.

## Interface
Parameters:
- OPW, 6, opcode width
- STW, 4, state register width (debug output)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  OPW  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (beq)
- i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  writeback source: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  destination register: 0 = rt, 1 = rd
- reg_write  output  1  register file write
- alu_src_a  output  1  ALU A: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  output  2  00 = add, 01 = sub, 10 = use funct
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reserved (never driven)
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- state_o  output  STW  current state encoding

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable; if entered, the next state is FETCH.
- FETCH drives: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle where mem_ready=1.
  - The FSM holds in FETCH while mem_ready=0, then moves to DECODE.
- DECODE drives: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 000000 → EXEC
  - 100011, 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other opcode → FETCH, with illegal_op=1 for that cycle
- MEMADR drives alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD for lw, MEMWR for sw.
- MEMRD drives mem_read=1, i_or_d=1. It holds until mem_ready=1, then moves to MEMWB.
- MEMWB drives reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
- MEMWR drives mem_write=1, i_or_d=1. It holds until mem_ready=1, then moves to FETCH.
- EXEC drives alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB drives reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next: FETCH.
- ADDIEX drives alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
- ADDIWB drives reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- JUMP drives pc_write=1, pc_source=10. Next: FETCH.
- Every output not listed for a state is 0.

## Timing
- State register updates on the rising edge of clk. Outputs are decoded combinationally from state. Only ir_write and pc_write in FETCH also depend on mem_ready.
- Reset (rst_n low) asynchronously forces state=FETCH. While rst_n is low:
  - pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write and illegal_op are forced to 0.
  - Selects take their FETCH values: i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, reg_dst=0, mem_to_reg=0.
  - state_o=0.
- The first fetch begins on the first clk edge after rst_n deasserts.
- Latency with mem_ready held at 1: R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3, illegal 2.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Requests stay asserted and stable while waiting.
- Reset asserted mid-instruction abandons the instruction immediately. No partial write enable is issued after the reset edge.

## Structure
- Package mips_ctrl_pkg holds:
  - state enum
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - encodings for alu_src_b, alu_op and pc_source
- Sub-module mips_ctrl_outdec is the purely combinational state → control-word decoder. The top level holds the state register, next-state logic and reset gating.

## Test plan
- Reset, then lw (opcode 100011) with mem_ready=1 → state sequence 0,1,2,3,4,0. reg_write=1 with mem_to_reg=1 only in state 4.
- R-type (000000) → EXEC shows alu_op=10, alu_src_b=00. ALUWB shows reg_dst=1, reg_write=1. Returns to FETCH after 4 cycles.
- beq (000100) → BRANCH shows pc_write_cond=1, pc_source=01, alu_op=01. j (000010) → JUMP shows pc_write=1, pc_source=10.
- sw with mem_ready low for 3 cycles in MEMWR → mem_write held at 1 for 4 cycles, then FETCH. In FETCH with mem_ready=0 → ir_write=0, pc_write=0, mem_read=1.
- Opcode 111111 → illegal_op pulses for 1 cycle in DECODE, next state FETCH. No reg_write or mem_write is issued.
- rst_n asserted in MEMWR while waiting → mem_write drops to 0 asynchronously, state_o=0. Normal fetch resumes after release.
